ws2812_frame_sequencer: RTL
===========================

# ws2812_frame_sequencer

Frame controller for the 4×4 WS2812 binary-clock display. On each refresh request it snapshots the four BCD time digits and the on/off colours, and streams 16 GRB pixel words to the WS2812 bit serializer over a valid/ready handshake. It then holds the line idle for the latch period and reports frame completion. It sits between the timekeeping counters and the serializer that drives `ws_data`.

## Interface
Parameters:
- `NUM_COLS`, 4: digit columns (h1, h0, m1, m0).
- `NUM_ROWS`, 4: bits per column (row 0 = LSB).
- `LATCH_CYCLES`, 600: idle clocks after the last pixel (≥50 µs at 12 MHz); minimum 1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `frame_req` in 1: single-cycle refresh request.
- `digits` in 16: {h1,h0,m1,m0}; `digits[3:0]` = h1.
- `colour_on` in 24: GRB word for a set bit.
- `colour_off` in 24: GRB word for a clear bit.
- `pix_data` out 24: GRB word to the serializer.
- `pix_valid` out 1: `pix_data` is valid.
- `pix_ready` in 1: serializer accepts the word.
- `latching` out 1: high during the latch gap.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse at the end of the latch gap.

## Operation
- States:
  - IDLE → LOAD on `frame_req` or a set `pending` flag.
  - LOAD → SEND in one cycle. LOAD captures `digits`, `colour_on` and `colour_off` into shadow registers and clears `pix_idx` and `pending`.
  - SEND → LATCH on the handshake of pixel `NUM_COLS*NUM_ROWS-1`.
  - LATCH → IDLE once `lat_cnt` reaches `LATCH_CYCLES-1`. `frame_done` pulses on that cycle.
- Pixel mapping:
  - col = `pix_idx / NUM_ROWS`, row = `pix_idx % NUM_ROWS`.
  - The lit bit is `shadow_digits[col*4 + row]`.
  - `pix_data` = lit ? shadow_on : shadow_off.
  - Mapping is linear, not serpentine.
- Handshake:
  - Transfer occurs when `pix_valid && pix_ready`.
  - `pix_valid` is high for the whole of SEND.
  - `pix_data` is stable while `pix_valid && !pix_ready`.
  - `pix_idx` advances only on a transfer.
- `pix_idx` width is `$clog2(NUM_COLS*NUM_ROWS)`. It does not wrap; exit at the last index.
- `lat_cnt` width is `$clog2(LATCH_CYCLES)`. It is cleared on entry to LATCH.
- Frame requests:
  - A `frame_req` while `busy` sets `pending`; multiple requests collapse into one.
  - Pending is serviced IDLE→LOAD on the cycle after `frame_done`.
  - A `frame_req` in the same cycle as `frame_done` also sets `pending`.
- Changes to `digits` or the colours mid-frame do not affect the current frame (no tearing).
- `pix_ready` outside SEND is ignored.
- Reset, including mid-frame:
  - State → IDLE.
  - `pix_valid`, `latching`, `busy`, `frame_done`, `pending` → 0.
  - `pix_data`, `pix_idx`, `lat_cnt` and the shadows → 0.
  - The interrupted frame is abandoned and not resumed.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from `pix_ready` to any output.
- Latency: `frame_req` at cycle N → LOAD at N+1 → `pix_valid` high with pixel 0 at N+2.
- A new pixel is presented the cycle after each transfer. With `pix_ready` held high, the frame takes exactly 16 SEND cycles.
- `latching` rises the cycle after the final transfer and stays high for exactly `LATCH_CYCLES` cycles.
- `frame_done` coincides with the last `latching` cycle.
- Back-to-back frames (pending set): IDLE lasts 1 cycle between `frame_done` and LOAD.
- Minimum frame length = 2 + 16 + `LATCH_CYCLES` cycles (+1 IDLE).

## Structure
- Package `ws2812_pkg`:
  - State enum (IDLE, LOAD, SEND, LATCH).
  - GRB colour typedef (24 bits, G[23:16], R[15:8], B[7:0]).
  - Default colour constants `COLOUR_OFF` = 24'h000000 and `COLOUR_ON` = 24'h000040.
- One sub-module: `ws2812_latch_timer`.
  - Load/count with a done pulse, parameterised by `LATCH_CYCLES`.
  - Reused by the serializer's own reset gap.

## Test plan
- Reset released, `digits`=16'h0000, ready held high, one `frame_req` → 16 words, all `colour_off`. `latching` high 600 cycles. One `frame_done` pulse; `busy` low after.
- `digits`=16'h9521 (h1=1, h0=2, m1=5, m0=9), `colour_on`=24'h00FF00 → lit indices exactly 0, 5, 8, 10, 12, 15; those 6 words = 24'h00FF00, the other 10 = `colour_off`.
- `pix_ready` toggled pseudo-randomly with 3-cycle stalls → `pix_data` never changes while stalled. Exactly 16 transfers, in order.
- Three `frame_req` pulses during SEND, one coincident with `frame_done` → exactly one extra frame starts 1 cycle after `frame_done`. Two frames total.
- `digits` changed from 16'h1234 to 16'hFFFF at pixel 7 → the remaining pixels still follow 16'h1234.
- `rst_n` asserted at pixel 9 with `pix_ready` low → `pix_valid` and `busy` drop immediately. After release there is no output until a new `frame_req`, which then restarts at pixel 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// +----------------------------------------------------------------------+
// | ws2812_pkg : shared types and constants for the WS2812 frame path    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package ws2812_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SEND  = 2'd2,
      ST_LATCH = 2'd3
   } frame_state_e;

   // G[23:16], R[15:8], B[7:0]
   typedef logic [23:0] grb_t;

   localparam grb_t COLOUR_OFF = 24'h000000;
   localparam grb_t COLOUR_ON  = 24'h000040;

   localparam int DIGIT_W = 4;

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_latch_timer.sv
// +----------------------------------------------------------------------+
// | ws2812_latch_timer : load-and-count gap timer with terminal pulse    |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module ws2812_latch_timer
   import ws2812_pkg::*;
#(
   parameter int LATCH_CYCLES = 600
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic active,
   output logic done
);

   localparam int               CNT_W = safe_clog2(LATCH_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(LATCH_CYCLES - 1);

   logic [CNT_W-1:0] lat_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         lat_cnt <= '0;
      end else if (load) begin
         active  <= 1'b1;
         lat_cnt <= '0;
      end else if (active) begin
         if (lat_cnt == LAST) begin
            active <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt + 1'b1;
         end
      end
   end

   // Decoded from registers only, so the pulse lands on the last active cycle.
   assign done = active && (lat_cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/ws2812_frame_sequencer.sv
// +----------------------------------------------------------------------+
// | ws2812_frame_sequencer : snapshots time digits and streams 16 GRB    |
// | pixel words to the serializer, then holds the latch gap.             |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ws2812_frame_sequencer
   import ws2812_pkg::*;
#(
   parameter int NUM_COLS     = 4,
   parameter int NUM_ROWS     = 4,
   parameter int LATCH_CYCLES = 600
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        frame_req,
   input  logic [NUM_COLS*DIGIT_W-1:0] digits,
   input  logic [23:0]                 colour_on,
   input  logic [23:0]                 colour_off,
   output logic [23:0]                 pix_data,
   output logic                        pix_valid,
   input  logic                        pix_ready,
   output logic                        latching,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int DIG_BITS = NUM_COLS * DIGIT_W;
   localparam int NUM_PIX  = NUM_COLS * NUM_ROWS;
   localparam int IDX_W    = safe_clog2(NUM_PIX);
   localparam int BIT_W    = safe_clog2(DIG_BITS);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);

   localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
   localparam logic [1:0] S_LOAD  = 2'(ST_LOAD);
   localparam logic [1:0] S_SEND  = 2'(ST_SEND);
   localparam logic [1:0] S_LATCH = 2'(ST_LATCH);

   logic [1:0]          state;
   logic                pending;
   logic [IDX_W-1:0]    pix_idx;
   logic [DIG_BITS-1:0] shadow_digits;
   logic [23:0]         shadow_on;
   logic [23:0]         shadow_off;

   logic xfer;
   logic last_xfer;
   logic lat_load;
   logic lat_active;
   logic lat_done;

   // Linear column-major mapping: each column is one BCD digit, row 0 its LSB.
   function automatic logic [23:0] pick_word(
      input logic [DIG_BITS-1:0] d,
      input logic [23:0]         on_word,
      input logic [23:0]         off_word,
      input int                  idx
   );
      int             col;
      int             row;
      logic [BIT_W-1:0] bit_sel;
      col     = idx / NUM_ROWS;
      row     = idx % NUM_ROWS;
      bit_sel = BIT_W'(col * DIGIT_W + row);
      return d[bit_sel] ? on_word : off_word;
   endfunction

   assign xfer      = (state == S_SEND) && pix_ready;
   assign last_xfer = xfer && (pix_idx == LAST_IDX);
   assign lat_load  = last_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         pix_idx       <= '0;
         pix_data      <= '0;
         shadow_digits <= '0;
         shadow_on     <= '0;
         shadow_off    <= COLOUR_OFF;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_req || pending) begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               state         <= S_SEND;
               shadow_digits <= digits;
               shadow_on     <= colour_on;
               shadow_off    <= colour_off;
               pix_idx       <= '0;
               pix_data      <= pick_word(digits, colour_on, colour_off, 0);
            end
            S_SEND: begin
               if (xfer) begin
                  if (pix_idx == LAST_IDX) begin
                     state <= S_LATCH;
                  end else begin
                     pix_idx  <= pix_idx + 1'b1;
                     pix_data <= pick_word(shadow_digits, shadow_on, shadow_off,
                                           int'(pix_idx) + 1);
                  end
               end
            end
            S_LATCH: begin
               if (lat_done) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // A request that arrives while busy (LOAD included) wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (frame_req && (state != S_IDLE)) begin
         pending <= 1'b1;
      end else if (state == S_LOAD) begin
         pending <= 1'b0;
      end
   end

   ws2812_latch_timer #(
      .LATCH_CYCLES (LATCH_CYCLES)
   ) u_latch_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (lat_load),
      .active (lat_active),
      .done   (lat_done)
   );

   assign pix_valid  = (state == S_SEND);
   assign busy       = (state != S_IDLE);
   assign latching   = lat_active;
   assign frame_done = lat_done && (state == S_LATCH);

endmodule

`default_nettype wire
